// File: rtl/ram_burst_master.sv
// -----------------------------------------------------------------------------
// ram_burst_master
//
// Initiator-side burst controller for a synchronous single-port RAM.
// A client hands over burst commands (start address + beat count). Write
// bursts stream client data straight onto the RAM bus. Read bursts issue RAM
// reads and return the data through a 3-entry first-word-fall-through skid
// FIFO.
//
// Handshake rule (cmd_*, wr_*, rd_*): a transfer happens on the rising clock
// edge that ends a cycle in which both valid and ready are high. valid never
// depends on ready. Neither side may retract anything mid-cycle.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   cmd_valid/ready/write/     burst command: direction, start address,
//   cmd_addr/len               beats minus one
//   wr_valid/ready/data        write beat stream (used only in WRITE)
//   rd_valid/ready/data        read beat stream out of the skid FIFO
//   busy                       high whenever the FSM is not IDLE
//   ram_cs/we/oe/addr/wdata    RAM control, registered address, write data
//   ram_rdata                  RAM read data (floats outside read cycles)
//   err                        only with RAM_BURST_MASTER_BOUND_CHECK_EN
//                              defined: one-cycle pulse after an accepted
//                              command that would run past the top of the RAM
//
// Optional feature macro: RAM_BURST_MASTER_BOUND_CHECK_EN
// -----------------------------------------------------------------------------
module ram_burst_master #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
`ifdef RAM_BURST_MASTER_BOUND_CHECK_EN
  ,
  output logic                  err
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  localparam logic [LEN_WIDTH:0]  ONE_BEAT = (LEN_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  state_t                state_q;
  state_t                state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH:0]    beats_q;     // beats still to move (up to 2**LEN_WIDTH)
  logic                  inflight_q;  // a read issued last cycle lands this cycle

  logic                  cmd_fire;
  logic                  wr_fire;
  logic                  issue;
  logic                  oob;
  logic                  start_burst;

  // Skid FIFO
  logic [DATA_WIDTH-1:0] fifo_mem [3];
  logic [1:0]            wr_ptr_q;
  logic [1:0]            rd_ptr_q;
  logic [1:0]            count_q;
  logic [2:0]            credit_used;
  logic                  push;
  logic                  pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // ---------------------------------------------------------------------------
  // Optional bound check: reject bursts that would run past the top address.
  // ---------------------------------------------------------------------------
`ifdef RAM_BURST_MASTER_BOUND_CHECK_EN
  localparam int SUM_W = ((ADDR_WIDTH > LEN_WIDTH) ? ADDR_WIDTH : LEN_WIDTH) + 2;
  logic [SUM_W-1:0] burst_end;
  logic [SUM_W-1:0] addr_limit;
  logic             err_q;

  assign burst_end  = SUM_W'(cmd_addr) + SUM_W'(cmd_len) + SUM_W'(1);
  assign addr_limit = SUM_W'(1) << ADDR_WIDTH;
  assign oob        = (burst_end > addr_limit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= cmd_fire && oob;
    end
  end

  assign err = err_q;
`else
  assign oob = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Handshake qualifiers
  // ---------------------------------------------------------------------------
  assign cmd_fire    = cmd_valid && cmd_ready;
  assign start_burst = cmd_fire && !oob;
  assign wr_fire     = (state_q == S_WRITE) && wr_valid;

  // A read may only issue when the FIFO is guaranteed room for it when it
  // lands: queued entries plus the one in flight must stay below the depth.
  assign credit_used = {1'b0, count_q} + {2'b00, inflight_q};
  assign issue       = (state_q == S_READ) && (beats_q != '0) && (credit_used < 3'd3);

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state and RAM/handshake outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    wr_ready  = 1'b0;
    ram_cs    = 1'b0;
    ram_we    = 1'b0;
    ram_oe    = 1'b0;
    ram_wdata = '0;

    case (state_q)
      S_IDLE: begin
        // Held low during reset so nothing is accepted while rst_n is low.
        cmd_ready = rst_n;
        if (start_burst) begin
          state_d = cmd_write ? S_WRITE : S_READ;
        end
      end

      S_WRITE: begin
        wr_ready  = 1'b1;
        ram_cs    = wr_valid;
        ram_we    = wr_valid;
        ram_wdata = wr_data;
        if (wr_fire && (beats_q == ONE_BEAT)) begin
          state_d = S_IDLE;
        end
      end

      S_READ: begin
        // The RAM is kept selected every cycle; non-issue cycles re-read the
        // held address and the result is simply not captured.
        ram_cs = 1'b1;
        ram_oe = 1'b1;
        if (issue && (beats_q == ONE_BEAT)) begin
          state_d = S_DRAIN;
        end
      end

      S_DRAIN: begin
        ram_cs = 1'b1;
        ram_oe = 1'b1;
        if (inflight_q) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy     = (state_q != S_IDLE);
  assign ram_addr = addr_q;

  // ---------------------------------------------------------------------------
  // Address / beat counters and in-flight tracking
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      beats_q    <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (start_burst) begin
        addr_q  <= cmd_addr;
        beats_q <= {1'b0, cmd_len} + ONE_BEAT;
      end else if (wr_fire || issue) begin
        // Address wraps naturally modulo 2**ADDR_WIDTH.
        addr_q  <= addr_q + ADDR_ONE;
        beats_q <= beats_q - ONE_BEAT;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Skid FIFO. ram_rdata is only looked at in capture cycles, so a floating
  // bus in any other cycle never reaches the storage.
  // ---------------------------------------------------------------------------
  assign push     = inflight_q;
  assign rd_valid = (count_q != 2'd0);
  assign pop      = rd_valid && rd_ready;
  assign rd_data  = rd_valid ? fifo_mem[rd_ptr_q] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_ram_burst_master.sv
`timescale 1ns/1ps
module tb_ram_burst_master;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int LW = 4;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [LW-1:0] cmd_len = '0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [DW-1:0] wr_data = '0;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic [DW-1:0] rd_data;
  logic          busy;
  logic          ram_cs;
  logic          ram_we;
  logic          ram_oe;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
`ifdef RAM_BURST_MASTER_BOUND_CHECK_EN
  logic          err;
`endif

  ram_burst_master #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .LEN_WIDTH (LW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_len  (cmd_len),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_data  (wr_data),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .busy     (busy),
    .ram_cs   (ram_cs),
    .ram_we   (ram_we),
    .ram_oe   (ram_oe),
    .ram_addr (ram_addr),
    .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
`ifdef RAM_BURST_MASTER_BOUND_CHECK_EN
    ,
    .err      (err)
`endif
  );

  // ---------------------------------------------------------------------------
  // RAM model: write on the edge ending a cs&we cycle; read data appears one
  // cycle after the read, only while cs&oe&!we. Otherwise the bus floats,
  // modelled as fresh garbage every cycle.
  // ---------------------------------------------------------------------------
  logic [DW-1:0] ram_mem [256];
  logic          rd_pend;
  logic [AW-1:0] rd_addr_q;
  logic [DW-1:0] bus_noise;

  always @(posedge clk) begin
    if (ram_cs && ram_we) ram_mem[ram_addr] <= ram_wdata;
    rd_pend   <= ram_cs && !ram_we;
    rd_addr_q <= ram_addr;
    bus_noise <= DW'($urandom);
  end

  always_comb begin
    ram_rdata = bus_noise;
    if (rd_pend && ram_cs && ram_oe && !ram_we) ram_rdata = ram_mem[rd_addr_q];
  end

  // ---------------------------------------------------------------------------
  // Reference model / scoreboard state
  // ---------------------------------------------------------------------------
  logic [DW-1:0] model_mem [int];   // address -> last word written by the bench
  logic [DW-1:0] exp_q [$];         // read beats still expected, in order
  logic [DW-1:0] wdata_q [$];       // data for the next write burst
  int n_checks = 0;
  int n_fail   = 0;

  // ---------------------------------------------------------------------------
  // Driver: one write burst, checking the RAM bus beat by beat.
  // ---------------------------------------------------------------------------
  task automatic run_write(input logic [AW-1:0] addr, input int len, input bit gaps,
                           input string tag);
    int sent = 0;
    int cyc = 0;
    logic [AW-1:0] exp_addr;
    exp_addr = addr;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = addr; cmd_len = LW'(len);
    #1;
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s_cmd_ready: got %b want 1", tag, cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    while (sent <= len && cyc < 200) begin
      wr_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      wr_data  = wdata_q[sent];
      #1;
      n_checks++;
      if (wr_ready !== 1'b1 || busy !== 1'b1 || ram_cs !== wr_valid ||
          ram_we !== wr_valid || ram_oe !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_wr_ctl: got rdy=%b busy=%b cs=%b we=%b oe=%b want 1 1 %b %b 0",
                 tag, wr_ready, busy, ram_cs, ram_we, ram_oe, wr_valid, wr_valid);
      end
      if (wr_valid) begin
        n_checks++;
        if (ram_addr !== exp_addr || ram_wdata !== wr_data) begin
          n_fail++;
          $display("FAIL %s_wr_beat%0d: got addr=%h data=%h want addr=%h data=%h",
                   tag, sent, ram_addr, ram_wdata, exp_addr, wr_data);
        end
        model_mem[int'(exp_addr)] = wr_data;
        exp_addr = exp_addr + AW'(1);
        sent++;
      end
      cyc++;
      @(negedge clk);
    end
    wr_valid = 1'b0;
    #1;
    n_checks++;
    if (sent != len + 1 || busy !== 1'b0 || cmd_ready !== 1'b1 || ram_cs !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_wr_end: got beats=%0d busy=%b cmd_ready=%b cs=%b want %0d 0 1 0",
               tag, sent, busy, cmd_ready, ram_cs, len + 1);
    end
    wdata_q.delete();
  endtask

  // ---------------------------------------------------------------------------
  // Driver: one read burst. mode 0 = rd_ready held high, 1 = random,
  // 2 = held high except 5 stalled cycles mid-burst.
  // ---------------------------------------------------------------------------
  task automatic run_read(input logic [AW-1:0] addr, input int len, input int mode,
                          input string tag);
    int total;
    int popped = 0;
    int k = 1;
    int max_out = 0;
    int first_valid = -1;
    int issued;
    logic [AW-1:0] diff;
    total = len + 1;
    exp_q.delete();
    for (int i = 0; i <= len; i++) exp_q.push_back(model_mem[int'(AW'(addr + AW'(i)))]);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = addr; cmd_len = LW'(len);
    #1;
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s_cmd_ready: got %b want 1", tag, cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    while (exp_q.size() != 0 && k < 300) begin
      if (mode == 0)      rd_ready = 1'b1;
      else if (mode == 1) rd_ready = 1'($urandom_range(0, 1));
      else                rd_ready = !(k >= 4 && k <= 8);
      #1;
      if (busy) begin
        // Beats issued so far are exactly how far the address has advanced.
        diff   = ram_addr - addr;
        issued = int'(diff);
        if (issued - popped > max_out) max_out = issued - popped;
        n_checks++;
        if (ram_cs !== 1'b1 || ram_oe !== 1'b1 || ram_we !== 1'b0 ||
            issued - popped > 3 || issued > total) begin
          n_fail++;
          $display("FAIL %s_rd_bus: got cs=%b oe=%b we=%b outstanding=%0d issued=%0d want 1 1 0 <=3 <=%0d",
                   tag, ram_cs, ram_oe, ram_we, issued - popped, issued, total);
        end
      end
      if (rd_valid === 1'b1 && first_valid < 0) first_valid = k;
      if (mode == 0 && k >= 3 && k < 3 + total) begin
        n_checks++;
        if (rd_valid !== 1'b1) begin
          n_fail++; $display("FAIL %s_rd_stream: got rd_valid=%b at cycle %0d want 1", tag, rd_valid, k);
        end
      end
      if (rd_valid === 1'b1 && rd_ready) begin
        n_checks++;
        if (rd_data !== exp_q[0]) begin
          n_fail++; $display("FAIL %s_rd_beat%0d: got %h want %h", tag, popped, rd_data, exp_q[0]);
        end
        void'(exp_q.pop_front());
        popped++;
      end
      k++;
      @(negedge clk);
    end
    rd_ready = 1'b0;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL %s_rd_timeout: got %0d beats want %0d", tag, popped, total);
    end
    if (mode == 0) begin
      n_checks++;
      if (first_valid != 3) begin
        n_fail++; $display("FAIL %s_rd_latency: got first rd_valid at cycle %0d want 3", tag, first_valid);
      end
    end
    if (mode == 2) begin
      n_checks++;
      if (max_out != 3) begin
        n_fail++; $display("FAIL %s_rd_credit: got max outstanding %0d want 3", tag, max_out);
      end
    end
    #1;
    n_checks++;
    if (busy !== 1'b0 || rd_valid !== 1'b0) begin
      n_fail++; $display("FAIL %s_rd_end: got busy=%b rd_valid=%b want 0 0", tag, busy, rd_valid);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (cmd_ready !== 1'b0 || busy !== 1'b0 || ram_cs !== 1'b0 || ram_we !== 1'b0 ||
        ram_oe !== 1'b0 || ram_addr !== '0 || rd_valid !== 1'b0 || wr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got rdy=%b busy=%b cs=%b we=%b oe=%b addr=%h rdv=%b wrr=%b want all 0",
               cmd_ready, busy, ram_cs, ram_we, ram_oe, ram_addr, rd_valid, wr_ready);
    end
`ifdef RAM_BURST_MASTER_BOUND_CHECK_EN
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++; $display("FAIL reset_err: got %b want 0", err);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_release: got rdy=%b busy=%b want 1 0", cmd_ready, busy);
    end
  endtask

  task automatic test_write_burst();
    for (int i = 0; i < 4; i++) wdata_q.push_back(DW'(8'hA1 + i));
    run_write(8'h10, 3, 1'b0, "write_burst");
  endtask

  task automatic test_read_burst();
    run_read(8'h10, 3, 0, "read_burst");
  endtask

  task automatic test_read_stall();
    for (int i = 0; i < 8; i++) wdata_q.push_back(DW'($urandom));
    run_write(8'h20, 7, 1'b1, "stall_fill");
    run_read(8'h20, 7, 2, "read_stall");
  endtask

`ifdef RAM_BURST_MASTER_BOUND_CHECK_EN
  task automatic test_bound();
    int cs_seen = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'hFE; cmd_len = LW'(2);
    wr_valid = 1'b1; wr_data = 8'h5A;
    #1;
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL bound_cmd_ready: got %b want 1", cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    n_checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL bound_err_pulse: got err=%b busy=%b want 1 0", err, busy);
    end
    for (int c = 0; c < 4; c++) begin
      if (ram_cs === 1'b1) cs_seen++;
      @(negedge clk);
      #1;
      n_checks++;
      if (err !== 1'b0) begin
        n_fail++; $display("FAIL bound_err_len: got err=%b %0d cycles later want 0", err, c + 1);
      end
    end
    wr_valid = 1'b0;
    n_checks++;
    if (cs_seen != 0) begin
      n_fail++; $display("FAIL bound_no_access: got %0d cs cycles want 0", cs_seen);
    end
  endtask
`else
  task automatic test_wrap();
    for (int i = 0; i < 3; i++) wdata_q.push_back(DW'($urandom));
    run_write(8'hFE, 2, 1'b0, "wrap_write");
    run_read(8'hFE, 2, 0, "wrap_read");
  endtask
`endif

  task automatic test_back_to_back();
    int cyc = 0;
    int popped = 0;
    exp_q.delete();
    exp_q.push_back(model_mem[8'h20]); exp_q.push_back(model_mem[8'h21]);
    exp_q.push_back(model_mem[8'h24]); exp_q.push_back(model_mem[8'h25]);
    rd_ready = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h20; cmd_len = LW'(1);
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    while (busy === 1'b1 && cyc < 20) begin
      @(negedge clk); #1; cyc++;
    end
    n_checks++;
    if (busy !== 1'b0 || rd_valid !== 1'b1 || cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL b2b_queued_idle: got busy=%b rd_valid=%b cmd_ready=%b want 0 1 1",
                         busy, rd_valid, cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h24; cmd_len = LW'(1);
    #1;
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL b2b_cmd_ready: got %b want 1", cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    // Two queued plus one fetched fill the FIFO; the last beat must wait.
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL b2b_credit_stall: got busy=%b want 1", busy);
    end
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 40) begin
      @(negedge clk);
      rd_ready = 1'b1;
      #1;
      if (rd_valid === 1'b1) begin
        n_checks++;
        if (rd_data !== exp_q[0]) begin
          n_fail++; $display("FAIL b2b_beat%0d: got %h want %h", popped, rd_data, exp_q[0]);
        end
        void'(exp_q.pop_front());
        popped++;
      end
      cyc++;
    end
    @(negedge clk);
    rd_ready = 1'b0;
    #1;
    n_checks++;
    if (popped != 4 || busy !== 1'b0 || rd_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_end: got beats=%0d busy=%b rd_valid=%b want 4 0 0", popped, busy, rd_valid);
    end
  endtask

  task automatic test_reset_mid_read();
    for (int i = 0; i < 16; i++) wdata_q.push_back(DW'($urandom));
    run_write(8'h40, 15, 1'b0, "rst_fill");
    rd_ready = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h40; cmd_len = LW'(15);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b1 || rd_valid !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_pre: got busy=%b rd_valid=%b want 1 1", busy, rd_valid);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (ram_cs !== 1'b0 || ram_oe !== 1'b0 || rd_valid !== 1'b0 || cmd_ready !== 1'b0 ||
        busy !== 1'b0 || ram_addr !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_abort: got cs=%b oe=%b rdv=%b rdy=%b busy=%b addr=%h want 0 0 0 0 0 00",
               ram_cs, ram_oe, rd_valid, cmd_ready, busy, ram_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (cmd_ready !== 1'b1 || rd_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_release: got rdy=%b rd_valid=%b want 1 0", cmd_ready, rd_valid);
    end
    for (int i = 0; i < 4; i++) wdata_q.push_back(DW'($urandom));
    run_write(8'h80, 3, 1'b1, "rst_write");
    run_read(8'h80, 3, 1, "rst_read");
  endtask

  task automatic test_random();
    int len;
    logic [AW-1:0] a;
    for (int it = 0; it < 6; it++) begin
      len = $urandom_range(0, 15);
`ifdef RAM_BURST_MASTER_BOUND_CHECK_EN
      a = AW'($urandom_range(0, 255 - len));
`else
      a = AW'($urandom_range(0, 255));
`endif
      for (int i = 0; i <= len; i++) wdata_q.push_back(DW'($urandom));
      run_write(a, len, 1'b1, "rand_write");
      run_read(a, len, 1, "rand_read");
    end
  endtask

  initial begin
    test_reset();
    test_write_burst();
    test_read_burst();
    test_read_stall();
`ifdef RAM_BURST_MASTER_BOUND_CHECK_EN
    test_bound();
`else
    test_wrap();
`endif
    test_back_to_back();
    test_reset_mid_read();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_burst_master.md
Name: ram_burst_master

Overview:
- Initiator-side controller for the team's synchronous single-port RAM interface: chip-select, write-enable, output-enable, address, write data and a tri-stated read-data bus.
- Accepts burst commands (start address, beat count) from a client over a valid/ready handshake.
- Streams write data into the RAM, or streams read data back out through a 3-entry skid FIFO.
- Sits between a DMA or test client and the RAM instance.

Parameters:
ADDR_WIDTH, 8, RAM address width; RAM depth is 2**ADDR_WIDTH words
DATA_WIDTH, 8, RAM word width
LEN_WIDTH, 4, width of cmd_len; a burst is cmd_len+1 beats

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when high with cmd_valid
cmd_write  in  1  1 = write burst, 0 = read burst
cmd_addr  in  ADDR_WIDTH  burst start address
cmd_len  in  LEN_WIDTH  beats minus one
wr_valid  in  1  write beat offered
wr_ready  out  1  write beat accepted
wr_data  in  DATA_WIDTH  write beat data
rd_valid  out  1  read beat available
rd_ready  in  1  client takes read beat
rd_data  out  DATA_WIDTH  read beat data
busy  out  1  state != IDLE
ram_cs  out  1  RAM chip select
ram_we  out  1  RAM write enable
ram_oe  out  1  RAM output enable
ram_addr  out  ADDR_WIDTH  RAM address (registered)
ram_wdata  out  DATA_WIDTH  RAM write data
ram_rdata  in  DATA_WIDTH  RAM read data; high-Z except in read-drive cycles

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - ram_cs, ram_we, ram_oe = 0; ram_addr = 0.
  - FIFO is flushed: rd_valid = 0.
  - cmd_ready = 0 while rst_n is low; wr_ready = 0; busy = 0; beat and in-flight counters cleared.
  - Reset mid-burst aborts the burst; the remaining beats are lost.
- RAM timing:
  - Write: a word is written on the clock edge ending any cycle where cs=1 and we=1.
  - Read: a read issued in cycle N (cs=1, we=0, ram_addr=A) presents MEM[A] on ram_rdata in cycle N+1, provided cs=1, oe=1 and we=0 in N+1.
- States: IDLE, WRITE, READ, DRAIN.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: load ram_addr=cmd_addr and beats=cmd_len+1, then go to WRITE if cmd_write=1, else READ.
- WRITE:
  - wr_ready=1; ram_cs=ram_we=wr_valid; ram_wdata=wr_data (combinational); ram_oe=0.
  - Each wr handshake writes one beat, increments ram_addr and decrements beats.
  - The last beat returns the block to IDLE. Maximum rate is 1 beat/cycle; wr_valid gaps stall the burst.
- READ and DRAIN:
  - ram_cs=1, ram_we=0, ram_oe=1 in every cycle.
  - READ issues a beat when beats>0 and fifo_count+inflight<3. The issued address is the current ram_addr; ram_addr then increments.
  - A beat issued in cycle N is captured into the FIFO at the end of N+1.
  - When the last beat has issued, go to DRAIN. DRAIN returns to IDLE after the last capture.
  - Non-issue cycles re-read the held address; the result is discarded.
- Latency and throughput:
  - Read: cmd handshake in cycle C, first issue in C+1, capture at end of C+2, rd_valid high from C+3.
  - With rd_ready held high, read throughput is 1 beat/cycle.
- FIFO:
  - 3 entries, first-word-fall-through.
  - Push and pop in the same cycle are allowed.
  - The FIFO never overflows because of the credit rule.
  - Contents survive the return to IDLE. A new command may be accepted while read data is still queued.
- Wrap-around: ram_addr wraps modulo 2**ADDR_WIDTH (0xFF -> 0x00).
- Gating outside bursts: wr_valid is ignored outside WRITE; rd_ready has no effect when rd_valid=0.
- ram_rdata is sampled only in capture cycles; an X or Z value in other cycles must not propagate.

Optional Feature:
Macro: RAM_BURST_MASTER_BOUND_CHECK_EN
- Defined:
  - Adds output err (1 bit, reset value 0).
  - A command with cmd_addr + cmd_len + 1 > 2**ADDR_WIDTH is accepted (cmd_ready=1), performs no RAM access and stays in IDLE.
  - err pulses high for one cycle after acceptance.
- Not defined: no err port; addresses wrap as described.

Test Plan:
- Write burst: addr 0x10, len 3, data 0xA1..0xA4, wr_valid held -> four consecutive cycles with cs=we=1 at addresses 0x10..0x13; busy falls after the 4th beat.
- Read of the same range with rd_ready=1 -> rd_valid rises 3 cycles after the cmd handshake, then 0xA1, 0xA2, 0xA3, 0xA4 on consecutive cycles.
- Read burst of len 7 with rd_ready low for 5 cycles mid-burst -> at most 3 beats queued, no issues while fifo_count+inflight=3, all 8 beats delivered in order with no duplicates.
- Write at addr 0xFE, len 2 -> writes land at 0xFE, 0xFF, 0x00 (macro off); with the macro on, err pulses for one cycle and no cs activity occurs.
- rst_n asserted low in the middle of a read burst -> ram_cs=0 and rd_valid=0 immediately; after release cmd_ready=1 and a fresh write/read pair returns correct data.
